game_cmd_scheduler: RTL and testbench

Sequences the Tetris-style game: turns the five debounced key-press levels from the keyboard controller and an internal gravity timer into a single, arbitrated command stream for the board engine. Owns the top-level game state (idle/play/pause/over), key auto-repeat, and the valid/ready handshake to the board engine. Sits between the keyboard controller and the board/collision logic.

---
 rtl/game_cmd_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_game_cmd_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_cmd_scheduler.sv
// Game sequencer: turns key levels and a gravity timer into one arbitrated
// valid/ready command stream for the board engine and owns the game state.
module game_cmd_scheduler #(
    parameter int REPEAT_DELAY   = 15000000,
    parameter int REPEAT_RATE    = 5000000,
    parameter int GRAVITY_PERIOD = 25000000,
    parameter int CNT_W          = 25
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       left_key_press,
    input  logic       right_key_press,
    input  logic       down_key_press,
    input  logic       play_key_press,
    input  logic       restart_key_press,
    input  logic       game_over,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_LEFT    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_DOWN    = 3'd3;
    localparam logic [2:0] CMD_GRAVITY = 3'd4;
    localparam logic [2:0] CMD_RESTART = 3'd5;

    localparam int K_PLAY    = 3;
    localparam int K_RESTART = 4;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] GRAV_LAST  = CNT_W'(GRAVITY_PERIOD - 1);

    // Fixed priority: elig = {restart, down, left, right, gravity}.
    function automatic logic [2:0] pick_cmd(input logic [4:0] elig);
        if (elig[4]) begin
            return CMD_RESTART;
        end else if (elig[3]) begin
            return CMD_DOWN;
        end else if (elig[2]) begin
            return CMD_LEFT;
        end else if (elig[1]) begin
            return CMD_RIGHT;
        end else if (elig[0]) begin
            return CMD_GRAVITY;
        end else begin
            return CMD_NONE;
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [4:0]       key_s, key_q_r, edge_s;
    logic [2:0]       move_pend_r, move_pend_nxt_s, move_req_s, move_clr_s;
    logic [2:0]       rep_hit_s, rep_phase_r, rep_phase_nxt_s;
    logic [CNT_W-1:0] rep_cnt_r [3];
    logic [CNT_W-1:0] rep_cnt_nxt_s [3];
    logic             grav_pend_r, grav_pend_nxt_s, grav_hit_s;
    logic [CNT_W-1:0] grav_cnt_r, grav_cnt_nxt_s;
    logic             rst_pend_r, rst_pend_nxt_s;
    logic             cmd_valid_r, cmd_valid_nxt_s;
    logic [2:0]       cmd_r, cmd_nxt_s, load_s;
    logic [4:0]       elig_s;
    logic             move_ok_s, down_xfer_s, arb_en_s;

    assign key_s  = {restart_key_press, play_key_press, down_key_press,
                     right_key_press, left_key_press};
    assign edge_s = key_s & ~key_q_r;

    // Game-state transitions; restart overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (edge_s[K_RESTART]) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = edge_s[K_PLAY] ? ST_PLAY : ST_IDLE;
                ST_PLAY: begin
                    if (game_over) begin
                        state_nxt_s = ST_OVER;
                    end else if (edge_s[K_PLAY]) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_PAUSE: state_nxt_s = edge_s[K_PLAY] ? ST_PLAY : ST_PAUSE;
                ST_OVER:  state_nxt_s = ST_OVER;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Requests only arise while staying in PLAY; the leaving edge flushes them.
    assign move_ok_s   = (state_r == ST_PLAY) && (state_nxt_s == ST_PLAY);
    assign down_xfer_s = cmd_valid_r && cmd_ready && (cmd_r == CMD_DOWN);

    // Auto-repeat counters for left/right/down: first DELAY, then RATE.
    always_comb begin
        rep_hit_s       = 3'b000;
        rep_phase_nxt_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rep_cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (!move_ok_s || !key_s[i] || edge_s[i]) begin
                rep_cnt_nxt_s[i]   = {CNT_W{1'b0}};
                rep_phase_nxt_s[i] = 1'b0;
            end else if (rep_cnt_r[i] == (rep_phase_r[i] ? RATE_LAST : DELAY_LAST)) begin
                rep_hit_s[i]       = 1'b1;
                rep_cnt_nxt_s[i]   = {CNT_W{1'b0}};
                rep_phase_nxt_s[i] = 1'b1;
            end else begin
                rep_cnt_nxt_s[i]   = rep_cnt_r[i] + CNT_W'(1);
                rep_phase_nxt_s[i] = rep_phase_r[i];
            end
        end
        move_req_s = move_ok_s ? (edge_s[2:0] | rep_hit_s) : 3'b000;
    end

    // Gravity timer: holds through PAUSE, cleared by IDLE/OVER or a soft drop.
    always_comb begin
        grav_hit_s     = 1'b0;
        grav_cnt_nxt_s = grav_cnt_r;
        if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_OVER) || down_xfer_s) begin
            grav_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (move_ok_s) begin
            if (grav_cnt_r == GRAV_LAST) begin
                grav_hit_s     = 1'b1;
                grav_cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                grav_cnt_nxt_s = grav_cnt_r + CNT_W'(1);
            end
        end else begin
            grav_cnt_nxt_s = grav_cnt_r;
        end
    end

    // Arbitration on an empty output or a transfer edge, plus pending-flag update.
    always_comb begin
        arb_en_s = !cmd_valid_r || cmd_ready;
        elig_s   = {rst_pend_r,
                    move_pend_r[2] & move_ok_s,
                    move_pend_r[0] & move_ok_s,
                    move_pend_r[1] & move_ok_s,
                    grav_pend_r & move_ok_s & ~down_xfer_s};
        if (arb_en_s) begin
            cmd_nxt_s       = pick_cmd(elig_s);
            cmd_valid_nxt_s = (cmd_nxt_s != CMD_NONE);
            load_s          = cmd_nxt_s;
        end else begin
            cmd_nxt_s       = cmd_r;
            cmd_valid_nxt_s = cmd_valid_r;
            load_s          = CMD_NONE;
        end
        move_clr_s = {load_s == CMD_DOWN, load_s == CMD_RIGHT, load_s == CMD_LEFT};
        if (move_ok_s) begin
            move_pend_nxt_s = (move_pend_r & ~move_clr_s) | move_req_s;
        end else begin
            move_pend_nxt_s = 3'b000;
        end
        if (move_ok_s && !down_xfer_s) begin
            grav_pend_nxt_s = (grav_pend_r & (load_s != CMD_GRAVITY)) | grav_hit_s;
        end else begin
            grav_pend_nxt_s = 1'b0;
        end
        rst_pend_nxt_s = (rst_pend_r & (load_s != CMD_RESTART)) | edge_s[K_RESTART];
    end

    // State, timer, pending and output registers.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            key_q_r     <= 5'b00000;
            move_pend_r <= 3'b000;
            rep_phase_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                rep_cnt_r[i] <= {CNT_W{1'b0}};
            end
            grav_pend_r <= 1'b0;
            grav_cnt_r  <= {CNT_W{1'b0}};
            rst_pend_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_r       <= CMD_NONE;
        end else begin
            state_r     <= state_nxt_s;
            key_q_r     <= key_s;
            move_pend_r <= move_pend_nxt_s;
            rep_phase_r <= rep_phase_nxt_s;
            for (int i = 0; i < 3; i++) begin
                rep_cnt_r[i] <= rep_cnt_nxt_s[i];
            end
            grav_pend_r <= grav_pend_nxt_s;
            grav_cnt_r  <= grav_cnt_nxt_s;
            rst_pend_r  <= rst_pend_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
            cmd_r       <= cmd_nxt_s;
        end
    end

    assign cmd_valid  = cmd_valid_r;
    assign cmd        = cmd_r;
    assign game_state = state_r;

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Directed bench for game_cmd_scheduler with short timer parameters.
module tb_game_cmd_scheduler;

    logic       CLK_50M;
    logic       RST_N;
    logic       left_key_press, right_key_press, down_key_press;
    logic       play_key_press, restart_key_press;
    logic       game_over;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic [1:0] game_state;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int         xfer_edge_q[$];
    logic [2:0] xfer_cmd_q[$];

    game_cmd_scheduler #(
        .REPEAT_DELAY  (8),
        .REPEAT_RATE   (4),
        .GRAVITY_PERIOD(20),
        .CNT_W         (25)
    ) dut (
        .CLK_50M          (CLK_50M),
        .RST_N            (RST_N),
        .left_key_press   (left_key_press),
        .right_key_press  (right_key_press),
        .down_key_press   (down_key_press),
        .play_key_press   (play_key_press),
        .restart_key_press(restart_key_press),
        .game_over        (game_over),
        .cmd_valid        (cmd_valid),
        .cmd              (cmd),
        .cmd_ready        (cmd_ready),
        .game_state       (game_state)
    );

    initial CLK_50M = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    always @(posedge CLK_50M) edge_cnt <= edge_cnt + 1;

    // Record each transfer with the number of the posedge on which it happens.
    always @(negedge CLK_50M) begin
        if (RST_N && cmd_valid && cmd_ready) begin
            xfer_edge_q.push_back(edge_cnt + 1);
            xfer_cmd_q.push_back(cmd);
        end
    end

    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic run_to(input int e);
        while (edge_cnt < e) tick();
    endtask

    task automatic clear_log();
        xfer_edge_q.delete();
        xfer_cmd_q.delete();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {left_key_press, right_key_press, down_key_press} = 3'b000;
        {play_key_press, restart_key_press, game_over} = 3'b000;
        cmd_ready = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        clear_log();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d expected 0", cmd_valid); end
        total++;
        if (cmd !== 3'd0) begin bad++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
        total++;
        if (game_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    endtask

    task automatic test_gravity();
        int k;
        do_reset();
        cmd_ready = 1'b1;
        play_key_press = 1'b1;
        tick();
        k = edge_cnt;
        play_key_press = 1'b0;
        total++;
        if (game_state !== 2'd1) begin bad++; $display("FAIL grav_state: got %0d expected 1", game_state); end
        run_to(k + 65);
        total++;
        if (xfer_edge_q.size() != 3) begin bad++; $display("FAIL grav_count: got %0d expected 3", xfer_edge_q.size()); end
        for (int i = 0; i < 3 && i < xfer_edge_q.size(); i++) begin
            total++;
            if (xfer_edge_q[i] != k + 22 + 20 * i || xfer_cmd_q[i] !== 3'd4) begin
                bad++;
                $display("FAIL grav_xfer%0d: got t=%0d cmd=%0d expected t=%0d cmd=4",
                         i, xfer_edge_q[i] - k, xfer_cmd_q[i], 22 + 20 * i);
            end
        end
    endtask

    task automatic test_left_repeat();
        int k;
        int got[$];
        int exp_t[7] = '{2, 10, 14, 18, 22, 26, 30};
        do_reset();
        cmd_ready = 1'b1;
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        tick();
        left_key_press = 1'b1;
        tick();
        k = edge_cnt;
        run_to(k + 29);
        left_key_press = 1'b0;
        run_to(k + 45);
        foreach (xfer_cmd_q[i]) if (xfer_cmd_q[i] == 3'd1) got.push_back(xfer_edge_q[i] - k);
        total++;
        if (got.size() != 7) begin bad++; $display("FAIL left_count: got %0d expected 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            total++;
            if (got[i] != exp_t[i]) begin bad++; $display("FAIL left_t%0d: got %0d expected %0d", i, got[i], exp_t[i]); end
        end
    endtask

    task automatic test_back_pressure();
        int p;
        do_reset();
        play_key_press = 1'b1;
        tick();
        p = edge_cnt;
        play_key_press = 1'b0;
        down_key_press = 1'b1;
        tick();
        down_key_press = 1'b0;
        left_key_press = 1'b1;
        tick();
        left_key_press = 1'b0;
        while (edge_cnt < p + 25) begin
            total++;
            if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
                bad++;
                $display("FAIL bp_hold: got valid=%0d cmd=%0d expected valid=1 cmd=3", cmd_valid, cmd);
            end
            tick();
        end
        clear_log();
        cmd_ready = 1'b1;
        run_to(p + 40);
        total++;
        if (xfer_edge_q.size() != 2) begin bad++; $display("FAIL bp_count: got %0d expected 2", xfer_edge_q.size()); end
        if (xfer_edge_q.size() >= 2) begin
            total++;
            if (xfer_cmd_q[0] !== 3'd3 || xfer_edge_q[0] != p + 26) begin
                bad++; $display("FAIL bp_first: got cmd=%0d t=%0d expected cmd=3 t=26", xfer_cmd_q[0], xfer_edge_q[0] - p);
            end
            total++;
            if (xfer_cmd_q[1] !== 3'd1 || xfer_edge_q[1] != p + 27) begin
                bad++; $display("FAIL bp_second: got cmd=%0d t=%0d expected cmd=1 t=27", xfer_cmd_q[1], xfer_edge_q[1] - p);
            end
        end
    endtask

    task automatic test_pause();
        int p, q;
        do_reset();
        play_key_press = 1'b1;
        tick();
        p = edge_cnt;
        play_key_press = 1'b0;
        left_key_press = 1'b1;
        tick();
        left_key_press = 1'b0;
        right_key_press = 1'b1;
        tick();
        right_key_press = 1'b0;
        tick();
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        total++;
        if (game_state !== 2'd2) begin bad++; $display("FAIL pause_state: got %0d expected 2", game_state); end
        run_to(p + 10);
        total++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
            bad++; $display("FAIL pause_hold: got valid=%0d cmd=%0d expected valid=1 cmd=1", cmd_valid, cmd);
        end
        clear_log();
        cmd_ready = 1'b1;
        run_to(p + 40);
        total++;
        if (xfer_edge_q.size() != 1) begin bad++; $display("FAIL pause_count: got %0d expected 1", xfer_edge_q.size()); end
        else begin
            total++;
            if (xfer_cmd_q[0] !== 3'd1 || xfer_edge_q[0] != p + 11) begin
                bad++; $display("FAIL pause_left: got cmd=%0d t=%0d expected cmd=1 t=11", xfer_cmd_q[0], xfer_edge_q[0] - p);
            end
        end
        clear_log();
        play_key_press = 1'b1;
        tick();
        q = edge_cnt;
        play_key_press = 1'b0;
        total++;
        if (game_state !== 2'd1) begin bad++; $display("FAIL resume_state: got %0d expected 1", game_state); end
        run_to(q + 25);
        total++;
        if (xfer_edge_q.size() != 1) begin bad++; $display("FAIL resume_count: got %0d expected 1", xfer_edge_q.size()); end
        else begin
            total++;
            if (xfer_cmd_q[0] !== 3'd4 || xfer_edge_q[0] != q + 19) begin
                bad++; $display("FAIL resume_grav: got cmd=%0d t=%0d expected cmd=4 t=19", xfer_cmd_q[0], xfer_edge_q[0] - q);
            end
        end
    endtask

    task automatic test_game_over();
        int r;
        do_reset();
        cmd_ready = 1'b1;
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        tick();
        play_key_press = 1'b1;
        game_over = 1'b1;
        tick();
        play_key_press = 1'b0;
        game_over = 1'b0;
        total++;
        if (game_state !== 2'd3) begin bad++; $display("FAIL over_state: got %0d expected 3", game_state); end
        clear_log();
        tick();
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        tick();
        total++;
        if (game_state !== 2'd3) begin bad++; $display("FAIL over_play_ignored: got %0d expected 3", game_state); end
        restart_key_press = 1'b1;
        tick();
        r = edge_cnt;
        restart_key_press = 1'b0;
        total++;
        if (game_state !== 2'd0) begin bad++; $display("FAIL restart_state: got %0d expected 0", game_state); end
        run_to(r + 10);
        total++;
        if (xfer_edge_q.size() != 1) begin bad++; $display("FAIL restart_count: got %0d expected 1", xfer_edge_q.size()); end
        else begin
            total++;
            if (xfer_cmd_q[0] !== 3'd5 || xfer_edge_q[0] != r + 2) begin
                bad++; $display("FAIL restart_cmd: got cmd=%0d t=%0d expected cmd=5 t=2", xfer_cmd_q[0], xfer_edge_q[0] - r);
            end
        end
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        tick();
        play_key_press = 1'b1;
        restart_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        restart_key_press = 1'b0;
        total++;
        if (game_state !== 2'd0) begin bad++; $display("FAIL play_restart_same: got %0d expected 0", game_state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        play_key_press = 1'b1;
        tick();
        play_key_press = 1'b0;
        left_key_press = 1'b1;
        tick();
        left_key_press = 1'b0;
        tick();
        total++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
            bad++; $display("FAIL areset_pre: got valid=%0d cmd=%0d expected valid=1 cmd=1", cmd_valid, cmd);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0 || game_state !== 2'd0) begin
            bad++; $display("FAIL areset_now: got valid=%0d cmd=%0d state=%0d expected 0 0 0", cmd_valid, cmd, game_state);
        end
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_left_repeat();
        test_back_pressure();
        test_pause();
        test_game_over();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
